// File: rtl/winograd_pkg.sv
// Shared constants and types for the Winograd tile scheduler and its tag FIFO.
package winograd_pkg;

   localparam int PE_LATENCY = 74;
   localparam int RD_LATENCY = 1;
   localparam int TILE_W     = 16;

   typedef logic [TILE_W-1:0] tile_idx_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/winograd_tile_scheduler_tag_fifo.sv
// In-flight tag FIFO: power-of-two depth, registered pointers, same-cycle push/pop.
module tag_fifo #(
   parameter int DEPTH = 128,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/winograd_tile_scheduler.sv
// Issues tile reads to a fixed-latency Winograd PE under a downstream credit limit
// and tags each PE result with the tile index it belongs to.
module winograd_tile_scheduler #(
   parameter int PE_LATENCY = winograd_pkg::PE_LATENCY,
   parameter int CREDITS    = 8,
   parameter int TAG_DEPTH  = 128
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [winograd_pkg::TILE_W-1:0] num_tiles,
   output logic                           busy,
   output logic                           done,
   output logic                           rd_en,
   output logic [winograd_pkg::TILE_W-1:0] rd_addr,
   output logic                           pe_next,
   input  logic                           pe_next_out,
   output logic                           res_valid,
   output logic [winograd_pkg::TILE_W-1:0] res_addr,
   input  logic                           res_credit,
   output logic                           err
);

   import winograd_pkg::*;

   localparam int CW    = $clog2(CREDITS + 1);
   localparam int FLUSH = PE_LATENCY + RD_LATENCY;
   localparam int FW    = $clog2(FLUSH + 1);

   state_t    state;
   tile_idx_t num_q;
   tile_idx_t issue_cnt;
   logic [CW-1:0] credits;
   logic [FW-1:0] flush_cnt;

   logic      fifo_full;
   logic      fifo_empty;
   tile_idx_t fifo_head;
   logic      issue;
   logic      flushing;
   logic      pop;
   logic      credit_ovf;
   logic      credit_in;

   // Tokens left inside the PE by a reset are discarded until they have drained out.
   assign flushing = (flush_cnt != '0);

   assign issue = (state == RUN) && (issue_cnt < num_q) && (credits != '0) && !fifo_full;

   assign pop       = pe_next_out && !flushing && !fifo_empty;
   assign res_valid = pop;
   assign res_addr  = pop ? fifo_head : '0;

   assign credit_ovf = res_credit && !issue && (credits == CW'(CREDITS));
   assign credit_in  = res_credit && !credit_ovf;

   tag_fifo #(
      .DEPTH (TAG_DEPTH),
      .WIDTH (TILE_W)
   ) u_tag_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (issue),
      .push_data (issue_cnt),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         pe_next   <= 1'b0;
         num_q     <= '0;
         issue_cnt <= '0;
         credits   <= CW'(CREDITS);
         flush_cnt <= FW'(FLUSH);
         err       <= 1'b0;
      end else begin
         rd_en   <= issue;
         pe_next <= rd_en;
         done    <= 1'b0;

         if (issue) begin
            rd_addr   <= issue_cnt;
            issue_cnt <= issue_cnt + TILE_W'(1);
         end

         if (flushing) flush_cnt <= flush_cnt - FW'(1);

         if ((pe_next_out && !flushing && fifo_empty) || credit_ovf) err <= 1'b1;

         if (issue && !credit_in)      credits <= credits - CW'(1);
         else if (!issue && credit_in) credits <= credits + CW'(1);

         case (state)
            IDLE: begin
               if (start) begin
                  num_q     <= num_tiles;
                  issue_cnt <= '0;
                  if (num_tiles != '0) begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            RUN: begin
               if (issue_cnt == num_q) state <= DRAIN;
            end
            DRAIN: begin
               // Wait until every issued tile has come back out of the PE.
               if (fifo_empty && !rd_en && !pe_next) begin
                  state <= DONE;
                  busy  <= 1'b0;
               end
            end
            DONE: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_winograd_tile_scheduler.sv
// Self-checking bench: PE/credit behavioural model, table-driven passes and corner sequences.
module tb_winograd_tile_scheduler;

   localparam int LAT = 74;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] num_tiles = '0;
   logic        busy, done, rd_en, pe_next, res_valid, err;
   logic [15:0] rd_addr, res_addr;
   logic        pe_next_out = 1'b0;
   logic        res_credit = 1'b0;

   always #5 clk = ~clk;

   winograd_tile_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .num_tiles   (num_tiles),
      .busy        (busy),
      .done        (done),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .pe_next     (pe_next),
      .pe_next_out (pe_next_out),
      .res_valid   (res_valid),
      .res_addr    (res_addr),
      .res_credit  (res_credit),
      .err         (err)
   );

   // PE model: next_out is next delayed LAT cycles; it keeps running through reset.
   logic [LAT:0] pipe = '0;
   logic auto_credit = 1'b1;
   logic man_credit  = 1'b0;
   logic spur        = 1'b0;
   logic rv_prev     = 1'b0;

   always @(posedge clk) begin
      #1;
      pipe        = {pipe[LAT-1:0], pe_next};
      pe_next_out = pipe[LAT] | spur;
      res_credit  = (auto_credit & rv_prev) | man_credit;
   end

   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;
   int iss_n, res_n, done_n, first_rd, last_rd, done_cyc, start_cyc;
   bit busy_seen;
   logic prev_rd = 1'b0;
   int exp_q[$];

   typedef struct {
      int n;
      int exp_iss;
      int exp_res;
      int exp_done;
      int exp_span;
   } vec_t;
   vec_t vecs[5];

   task automatic check(string name, longint act, longint expv);
      total_cnt++;
      if (act == expv) pass_cnt++;
      else $display("FAIL %s: got %0d, required %0d", name, act, expv);
   endtask

   task automatic clear_counts();
      iss_n = 0; res_n = 0; done_n = 0; first_rd = -1; last_rd = -1;
      done_cyc = -1; busy_seen = 0;
   endtask

   // Advance one cycle and observe outputs at the falling edge.
   task automatic step();
      @(negedge clk);
      cyc++;
      rv_prev = res_valid;
      if (reset) begin
         if (pe_next || prev_rd) check("pe_next_delay", pe_next, prev_rd);
         if (rd_en) begin
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            iss_n++;
         end
         if (res_valid) begin
            res_n++;
            if (exp_q.size() == 0) check("res_unexpected", res_valid, 0);
            else check("res_addr", res_addr, exp_q.pop_front());
         end
         if (done) begin
            done_n++;
            done_cyc = cyc;
         end
         if (busy) busy_seen = 1;
      end
      prev_rd = reset ? rd_en : 1'b0;
   endtask

   task automatic begin_pass(int n);
      clear_counts();
      for (int i = 0; i < n; i++) exp_q.push_back(i);
      start = 1'b1;
      num_tiles = 16'(n);
      start_cyc = cyc;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(int bound);
      for (int i = 0; i < bound; i++) begin
         if (done_n > 0) break;
         step();
      end
      repeat (4) step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{5, 5, 5, 1, 4};
      vecs[1] = '{1, 1, 1, 1, 0};
      vecs[2] = '{8, 8, 8, 1, 7};
      vecs[3] = '{12, 12, 12, 1, -1};
      vecs[4] = '{0, 0, 0, 1, -1};

      clear_counts();
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_pe_next", pe_next, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_res_addr", res_addr, 0);
      check("rst_err", err, 0);
      reset = 1'b1;
      step();

      // Table-driven passes with credits returned one cycle after each result.
      for (int v = 0; v < 5; v++) begin
         begin_pass(vecs[v].n);
         wait_done(600);
         check($sformatf("v%0d_issues", v), iss_n, vecs[v].exp_iss);
         check($sformatf("v%0d_results", v), res_n, vecs[v].exp_res);
         check($sformatf("v%0d_done", v), done_n, vecs[v].exp_done);
         check($sformatf("v%0d_err", v), err, 0);
         check($sformatf("v%0d_busy_end", v), busy, 0);
         check($sformatf("v%0d_sb_empty", v), exp_q.size(), 0);
         check($sformatf("v%0d_busy_seen", v), busy_seen, vecs[v].n != 0);
         if (vecs[v].exp_span >= 0)
            check($sformatf("v%0d_no_bubble", v), last_rd - first_rd, vecs[v].exp_span);
         if (vecs[v].n == 0)
            check("zero_done_latency", done_cyc - start_cyc, 2);
      end

      // Credits withheld: stall after CREDITS issues, one credit releases one issue.
      auto_credit = 1'b0;
      begin_pass(20);
      repeat (200) step();
      check("stall_issues", iss_n, 8);
      check("stall_results", res_n, 8);
      man_credit = 1'b1;
      step();
      man_credit = 1'b0;
      repeat (20) step();
      check("one_credit_one_issue", iss_n, 9);
      man_credit = 1'b1;
      repeat (7) step();
      man_credit = 1'b0;
      auto_credit = 1'b1;
      wait_done(800);
      check("stall_total_results", res_n, 20);
      check("stall_done", done_n, 1);
      check("stall_err", err, 0);

      // Start during RUN is ignored.
      begin_pass(10);
      repeat (3) step();
      start = 1'b1;
      num_tiles = 16'd3;
      step();
      start = 1'b0;
      wait_done(600);
      repeat (100) step();
      check("restart_issues", iss_n, 10);
      check("restart_results", res_n, 10);
      check("restart_done", done_n, 1);
      check("restart_err", err, 0);

      // Reset in the middle of a long pass.
      begin_pass(100);
      for (int i = 0; i < 300; i++) begin
         if (iss_n >= 30) break;
         step();
      end
      check("midrst_reached_30", iss_n >= 30, 1);
      reset = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_rd_en", rd_en, 0);
      check("midrst_pe_next", pe_next, 0);
      check("midrst_res_valid", res_valid, 0);
      check("midrst_rd_addr", rd_addr, 0);
      check("midrst_res_addr", res_addr, 0);
      check("midrst_err", err, 0);
      exp_q.delete();
      clear_counts();
      step();
      step();
      reset = 1'b1;
      repeat (80) step();
      check("flush_no_res_valid", res_n, 0);
      check("flush_err", err, 0);
      begin_pass(4);
      wait_done(400);
      check("post_rst_results", res_n, 4);
      check("post_rst_done", done_n, 1);
      check("post_rst_err", err, 0);

      // Spurious next_out while idle is sticky until reset.
      clear_counts();
      spur = 1'b1;
      step();
      spur = 1'b0;
      repeat (3) step();
      check("spur_err", err, 1);
      check("spur_no_res", res_n, 0);
      repeat (20) step();
      check("spur_err_sticky", err, 1);
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
      check("err_cleared", err, 0);

      // Credit returned while already holding all credits.
      man_credit = 1'b1;
      step();
      man_credit = 1'b0;
      repeat (3) step();
      check("credit_ovf_err", err, 1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/winograd_tile_scheduler.md
WINOGRAD_TILE_SCHEDULER -- requirements
Module: winograd_tile_scheduler

Interface
REQ-001 Parameter PE_LATENCY, default 74: fixed next-to-next_out latency of the Winograd processing element.
REQ-002 Parameter CREDITS, default 8: result-buffer slots downstream.
REQ-003 Parameter TAG_DEPTH, default 128: in-flight tag FIFO depth; SHALL be a power of two ≥ PE_LATENCY+2.
REQ-004 Ports SHALL be, one per line:
 clk  in  1  single clock, rising edge
 reset  in  1  asynchronous, active-low reset
 start  in  1  one-cycle pulse, begin a layer pass
 num_tiles  in  16  tiles in the pass, sampled on accepted start
 busy  out  1  pass in progress
 done  out  1  one-cycle pulse, pass complete
 rd_en  out  1  tile/filter buffer read strobe
 rd_addr  out  16  tile index read this cycle
 pe_next  out  1  to PE next; asserted 1 cycle after rd_en (buffer read latency 1)
 pe_next_out  in  1  from PE next_out
 res_valid  out  1  PE data_out valid this cycle
 res_addr  out  16  tile index of current PE result
 res_credit  in  1  downstream freed one result slot
 err  out  1  sticky error: unexpected next_out or credit overflow

Function
REQ-005 FSM states IDLE, RUN, DRAIN, DONE.
REQ-006 IDLE: start=1 latches num_tiles, clears issue counter; → RUN if num_tiles≠0, else → DONE.
REQ-007 start while not IDLE SHALL be ignored.
REQ-008 RUN: issue when issue_cnt<num_tiles_q AND credits>0 AND tag FIFO not full; issue = rd_en=1, rd_addr=issue_cnt, push issue_cnt to tag FIFO, issue_cnt+1, credits−1.
REQ-009 Max issue rate one tile per cycle; no bubbles while conditions of REQ-008 hold.
REQ-010 pe_next SHALL equal rd_en delayed by exactly one register stage.
REQ-011 RUN → DRAIN in the cycle after the last issue (issue_cnt==num_tiles_q).
REQ-012 DRAIN → DONE when tag FIFO empty and pe_next stage idle; DONE asserts done=1 for one cycle, → IDLE.
REQ-013 busy=1 in RUN and DRAIN, 0 in IDLE and DONE.
REQ-014 On pe_next_out=1 with tag FIFO non-empty: res_valid=1, res_addr=FIFO head (combinational, same cycle), pop.
REQ-015 pe_next_out=1 with tag FIFO empty outside flush window: res_valid=0, err set.
REQ-016 Credit counter range 0..CREDITS, reset to CREDITS; issue and res_credit same cycle → unchanged.
REQ-017 res_credit at credits==CREDITS without simultaneous issue: ignored, err set.
REQ-018 Results SHALL emerge in issue order; res_addr sequence 0..num_tiles_q−1.
REQ-019 Tag FIFO push and pop in the same cycle SHALL both occur, including when full (pop frees slot) or empty-with-bypass forbidden (empty pop is error per REQ-015).

Reset
REQ-020 reset low asynchronously forces: IDLE, busy=0, done=0, rd_en=0, pe_next=0, res_valid=0, rd_addr=0, res_addr=0, err=0, credits=CREDITS, tag FIFO empty, issue_cnt=0.
REQ-021 After reset release, flush counter SHALL ignore pe_next_out (no res_valid, no err) for PE_LATENCY+1 cycles, discarding tokens left in the PE by a mid-pass reset.
REQ-022 start during flush window SHALL be accepted; issues in that window are unaffected since their next_out arrives after it.

Structure
REQ-023 PE_LATENCY, RD_LATENCY=1, tile-index width and FSM state enum SHALL live in shared package winograd_pkg.
REQ-024 Tag FIFO SHALL be sub-module tag_fifo (parameterised depth/width, registered pointers, full/empty, same-cycle push/pop).

Verification
REQ-025 num_tiles=5, credits always returned 1 cycle after res_valid: rd_en cycles t0..t0+4, pe_next t0+1..t0+5, res_addr 0..4 at PE outputs, done once, err=0.
REQ-026 num_tiles=20, res_credit held 0: exactly 8 issues, then stall; returning 1 credit → exactly 1 more issue.
REQ-027 num_tiles=0: done pulses 2 cycles after start, no rd_en, busy stays 0.
REQ-028 Reset asserted at 30th issue of 100-tile pass: outputs reset immediately; residual next_out pulses within 75 cycles produce no res_valid, err=0.
REQ-029 Idle, spurious pe_next_out after flush window → err=1, stays 1 until reset; res_credit at full credits → err=1.
REQ-030 start pulsed during RUN of 10-tile pass: ignored, exactly 10 results, single done.
